seq_alu: RTL

- Multi-cycle arithmetic/shift unit directly downstream of the register file.
- Consumes the two register-read operands and produces a result for register write-back. It covers MUL and the variable shifts/rotate that the single-cycle ALU cannot complete in one cycle.
- Drives BUSY so the control unit stalls the PC and register write. Pulses DONE for exactly one cycle, during which RESULT is written back.

---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu_step.sv | 40 ++++
 rtl/seq_alu.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential multiply/shift unit: opcodes, FSM states
// and default sizing.
package seq_alu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_MUL = 3'b000,
    OP_SLL = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the control unit (master) and seq_alu (slave).
// OVF exists only when SEQ_ALU_OVF_EN is defined.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic [2:0]       OPCODE;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [WIDTH-1:0] RESULT;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
`ifdef SEQ_ALU_OVF_EN
  logic             OVF;

  modport master (output START, OPCODE, DATA1, DATA2,
                  input  RESULT, BUSY, DONE, ERR, OVF);
  modport slave  (input  START, OPCODE, DATA1, DATA2,
                  output RESULT, BUSY, DONE, ERR, OVF);
`else
  modport master (output START, OPCODE, DATA1, DATA2,
                  input  RESULT, BUSY, DONE, ERR);
  modport slave  (input  START, OPCODE, DATA1, DATA2,
                  output RESULT, BUSY, DONE, ERR);
`endif
endinterface

// File: rtl/seq_alu_step.sv
// One iteration of the latched operation: a shift-add step for MUL, or a
// single-bit shift/rotate of the working value. Purely combinational.
module seq_alu_step
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic [ACC_W-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  input  logic [ACC_W-1:0] acc_i,
  output logic [WIDTH-1:0] val_o,
  output logic [ACC_W-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o,
  output logic [ACC_W-1:0] acc_o
);

  always_comb begin
    val_o    = val_i;
    mcand_o  = mcand_i;
    mplier_o = mplier_i;
    acc_o    = acc_i;
    case (op_i)
      OP_MUL: begin
        // Multiplier consumed LSB first; multiplicand doubles each step.
        acc_o    = mplier_i[0] ? acc_i + mcand_i : acc_i;
        mcand_o  = mcand_i << 1;
        mplier_o = mplier_i >> 1;
      end
      OP_SLL:  val_o = {val_i[WIDTH-2:0], 1'b0};
      OP_SRL:  val_o = {1'b0, val_i[WIDTH-1:1]};
      OP_SRA:  val_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
      OP_ROR:  val_o = {val_i[0], val_i[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle MUL/shift/rotate unit with IDLE/RUN/DONE handshake.
// Define SEQ_ALU_OVF_EN for a full-width product accumulator and the OVF flag.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic     CLK,
  input  logic     RESET,
  seq_alu_if.slave bus
);

`ifdef SEQ_ALU_OVF_EN
  localparam int ACC_W = 2 * WIDTH;
`else
  localparam int ACC_W = WIDTH;
`endif
  localparam int SH_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
`ifdef SEQ_ALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0] val_s, mplier_s;
  logic [ACC_W-1:0] mcand_s, acc_s;
  logic [CNT_W-1:0] n_start;
  logic             accept;

  seq_alu_step #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_step (
    .op_i     (op_q),
    .val_i    (val_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_i    (acc_q),
    .val_o    (val_s),
    .mcand_o  (mcand_s),
    .mplier_o (mplier_s),
    .acc_o    (acc_s)
  );

  // Iteration count for the operation being offered on the bus.
  always_comb begin
    n_start = '0;
    case (bus.OPCODE)
      OP_MUL:                 n_start = CNT_W'(WIDTH);
      OP_SLL, OP_SRL, OP_SRA: n_start = (bus.DATA2 >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH)
                                                                      : CNT_W'(bus.DATA2);
      OP_ROR:                 n_start = CNT_W'(bus.DATA2[SH_W-1:0]);
      default:                n_start = '0;
    endcase
  end

  assign accept = bus.START && (state_q != ST_RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    val_d    = val_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    err_d    = err_q;
`ifdef SEQ_ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          op_d     = bus.OPCODE;
          val_d    = bus.DATA1;
          mcand_d  = ACC_W'(bus.DATA1);
          mplier_d = bus.DATA2;
          acc_d    = '0;
          cnt_d    = n_start;
          err_d    = !op_valid(bus.OPCODE);
`ifdef SEQ_ALU_OVF_EN
          ovf_d    = 1'b0;
`endif
          if (n_start == '0) begin
            // Zero-step ops finish straight away; invalid opcodes report zero.
            state_d  = ST_DONE;
            result_d = op_valid(bus.OPCODE) ? bus.DATA1 : '0;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d    = cnt_q - 1'b1;
        val_d    = val_s;
        mcand_d  = mcand_s;
        mplier_d = mplier_s;
        acc_d    = acc_s;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = (op_q == OP_MUL) ? acc_s[WIDTH-1:0] : val_s;
`ifdef SEQ_ALU_OVF_EN
          ovf_d    = (op_q == OP_MUL) && (|acc_s[ACC_W-1:WIDTH]);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      val_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      val_q    <= val_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      err_q    <= err_d;
`ifdef SEQ_ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.RESULT = result_q;
  assign bus.BUSY   = (state_q == ST_RUN);
  assign bus.DONE   = (state_q == ST_DONE);
  assign bus.ERR    = err_q;
`ifdef SEQ_ALU_OVF_EN
  assign bus.OVF    = ovf_q;
`endif

endmodule
